// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment readback path.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_DIGIT_0 = 7'b1000000;
    localparam seg7_t SEG_DIGIT_1 = 7'b1111001;
    localparam seg7_t SEG_DIGIT_2 = 7'b0100100;
    localparam seg7_t SEG_DIGIT_3 = 7'b0110000;
    localparam seg7_t SEG_DIGIT_4 = 7'b0011001;
    localparam seg7_t SEG_DIGIT_5 = 7'b0010010;
    localparam seg7_t SEG_DIGIT_6 = 7'b0000010;
    localparam seg7_t SEG_DIGIT_7 = 7'b1111000;
    localparam seg7_t SEG_DIGIT_8 = 7'b0000000;
    localparam seg7_t SEG_DIGIT_9 = 7'b0010000;
    localparam seg7_t SEG_BLANK   = 7'b1111111;

    localparam logic [3:0] MAX_TENS = 4'd3;

    typedef enum logic [1:0] {
        SETTLE,
        ACCEPT,
        HOLD,
        ERROR
    } dec_state_t;

    // Two-digit decimal to binary; the largest legal pair is 39.
    function automatic logic [5:0] pair_value(input logic [3:0] tens, input logic [3:0] units);
        pair_value = ({2'b00, tens} << 3) + ({2'b00, tens} << 1) + {2'b00, units};
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern to a BCD digit.
// Anything outside the ten digit glyphs is reported as illegal.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  seg7_t      seg,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_DIGIT_0: digit = 4'd0;
            SEG_DIGIT_1: digit = 4'd1;
            SEG_DIGIT_2: digit = 4'd2;
            SEG_DIGIT_3: digit = 4'd3;
            SEG_DIGIT_4: digit = 4'd4;
            SEG_DIGIT_5: digit = 4'd5;
            SEG_DIGIT_6: digit = 4'd6;
            SEG_DIGIT_7: digit = 4'd7;
            SEG_DIGIT_8: digit = 4'd8;
            SEG_DIGIT_9: digit = 4'd9;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Glitch-filtered readback of a two-digit 7-segment display into a 0..39 value.
// Define SEG7_BLANK_LEADING_EN to accept a blank tens digit as a leading zero.
module seg7_pair_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_units,
    output logic [5:0] value,
    output logic       value_valid,
    output logic       value_strobe,
    output logic       pattern_err
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    // Index 0 is the units digit, index 1 the tens digit.
    seg7_t       seg_in     [2];
    seg7_t       sample_reg [2];
    logic [3:0]  digit      [2];
    logic        legal      [2];

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    dec_state_t       state_reg, state_next;
    logic [5:0]       value_reg, value_next;
    logic             valid_reg, valid_next;
    logic             strobe_reg, strobe_next;
    logic             err_reg, err_next;
    logic             have_value_reg, have_value_next;

    logic             changed;
    logic [3:0]       tens_digit;
    logic             tens_legal;
    logic             pair_legal;
    logic [5:0]       new_value;

    assign seg_in[0] = seg_units;
    assign seg_in[1] = seg_tens;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            seg7_digit_decode u_dec (
                .seg   (sample_reg[gi]),
                .digit (digit[gi]),
                .legal (legal[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) sample_reg[i] <= SEG_BLANK;
            else        sample_reg[i] <= seg_in[i];
        end
    end

    assign changed = (seg_in[0] != sample_reg[0]) || (seg_in[1] != sample_reg[1]);

`ifdef SEG7_BLANK_LEADING_EN
    always_comb begin
        if (sample_reg[1] == SEG_BLANK) begin
            tens_digit = 4'd0;
            tens_legal = 1'b1;
        end else begin
            tens_digit = digit[1];
            tens_legal = legal[1] && (digit[1] <= MAX_TENS);
        end
    end
`else
    always_comb begin
        tens_digit = digit[1];
        tens_legal = legal[1] && (digit[1] <= MAX_TENS);
    end
`endif

    assign pair_legal = tens_legal && legal[0];
    assign new_value  = pair_value(tens_digit, digit[0]);

    always_comb begin
        if (changed)                  cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt_reg >= STABLE_CNT) cnt_next = STABLE_CNT;
        else                          cnt_next = cnt_reg + 1'b1;
    end

    // The accept decision uses the stored samples; a change arriving on the
    // same edge takes priority and restarts the count.
    always_comb begin
        state_next      = state_reg;
        value_next      = value_reg;
        valid_next      = valid_reg;
        strobe_next     = 1'b0;
        err_next        = err_reg;
        have_value_next = have_value_reg;
        case (state_reg)
            SETTLE: begin
                if (!changed && cnt_reg == STABLE_CNT) begin
                    if (pair_legal) begin
                        state_next      = ACCEPT;
                        value_next      = new_value;
                        valid_next      = 1'b1;
                        err_next        = 1'b0;
                        strobe_next     = (new_value != value_reg) || !have_value_reg;
                        have_value_next = 1'b1;
                    end else begin
                        state_next = ERROR;
                        err_next   = 1'b1;
                        valid_next = 1'b0;
                    end
                end
            end
            ACCEPT: begin
                if (changed) begin
                    state_next = SETTLE;
                    valid_next = 1'b0;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (changed) begin
                    state_next = SETTLE;
                    valid_next = 1'b0;
                end
            end
            ERROR: begin
                if (changed) begin
                    state_next = SETTLE;
                    err_next   = 1'b0;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= SETTLE;
            cnt_reg        <= '0;
            value_reg      <= '0;
            valid_reg      <= 1'b0;
            strobe_reg     <= 1'b0;
            err_reg        <= 1'b0;
            have_value_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            value_reg      <= value_next;
            valid_reg      <= valid_next;
            strobe_reg     <= strobe_next;
            err_reg        <= err_next;
            have_value_reg <= have_value_next;
        end
    end

    assign value        = value_reg;
    assign value_valid  = valid_reg;
    assign value_strobe = strobe_reg;
    assign pattern_err  = err_reg;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed bench for seg7_pair_decoder: exact-latency checks plus a strobe
// scoreboard that pops one expected value per observed value_strobe pulse.
module tb_seg7_pair_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_tens;
    logic [6:0] seg_units;
    logic [5:0] value;
    logic       value_valid;
    logic       value_strobe;
    logic       pattern_err;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    logic [5:0] sb [$];
    logic prev_strobe = 1'b0;

    seg7_pair_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_tens     (seg_tens),
        .seg_units    (seg_units),
        .value        (value),
        .value_valid  (value_valid),
        .value_strobe (value_strobe),
        .pattern_err  (pattern_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [6:0] t, input logic [6:0] u);
        seg_tens  = t;
        seg_units = u;
    endtask

    // Apply a digit pair and check the exact settle latency of 5 edges.
    task automatic accept_check(input int t, input int u, input logic exp_strobe);
        logic [5:0] exp_val;
        exp_val = 6'(t * 10 + u);
        if (exp_strobe) sb.push_back(exp_val);
        apply(pat_of(t), pat_of(u));
        tick(4);
        check("pre_accept_strobe", {7'b0, value_strobe}, 8'd0);
        check("pre_accept_valid", {7'b0, value_valid}, 8'd0);
        tick(1);
        check("accept_strobe", {7'b0, value_strobe}, {7'b0, exp_strobe});
        check("accept_valid", {7'b0, value_valid}, 8'd1);
        check("accept_value", {2'b0, value}, {2'b0, exp_val});
        check("accept_err", {7'b0, pattern_err}, 8'd0);
        tick(1);
        check("post_accept_strobe", {7'b0, value_strobe}, 8'd0);
    endtask

    // Scoreboard side: every strobe must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (value_strobe === 1'b1) begin
                check("strobe_gap", {7'b0, prev_strobe}, 8'd0);
                check("strobe_expected", {7'b0, (sb.size() != 0)}, 8'd1);
                if (sb.size() != 0) check("sb_value", {2'b0, value}, {2'b0, sb.pop_front()});
            end
            prev_strobe = value_strobe;
        end
    end

    initial begin
        rst_n = 1'b0;
        apply(7'h7F, 7'h7F);
        tick(3);
        check("rst_value", {2'b0, value}, 8'd0);
        check("rst_valid", {7'b0, value_valid}, 8'd0);
        check("rst_strobe", {7'b0, value_strobe}, 8'd0);
        check("rst_err", {7'b0, pattern_err}, 8'd0);

        // 09 right out of reset
        rst_n = 1'b1;
        accept_check(0, 9, 1'b1);

        // 21 then long quiet hold
        accept_check(2, 1, 1'b1);
        tick(50);
        check("hold_value", {2'b0, value}, 8'd21);
        check("hold_valid", {7'b0, value_valid}, 8'd1);

        // units toggling 3/4 never settles
        for (int k = 0; k < 10; k++) begin
            apply(pat_of(3), pat_of((k % 2 == 0) ? 4 : 3));
            for (int c = 0; c < 2; c++) begin
                tick(1);
                check("toggle_valid", {7'b0, value_valid}, 8'd0);
                check("toggle_strobe", {7'b0, value_strobe}, 8'd0);
            end
        end
        accept_check(3, 4, 1'b1);

        // illegal tens digit 4
        apply(pat_of(4), pat_of(0));
        tick(4);
        check("err_pre", {7'b0, pattern_err}, 8'd0);
        tick(1);
        check("err_set", {7'b0, pattern_err}, 8'd1);
        check("err_valid", {7'b0, value_valid}, 8'd0);
        check("err_value_kept", {2'b0, value}, 8'd34);
        tick(3);
        check("err_held", {7'b0, pattern_err}, 8'd1);
        accept_check(3, 0, 1'b1);

        // change on the edge the count completes: no accept of 11
        apply(pat_of(1), pat_of(1));
        tick(4);
        accept_check(1, 7, 1'b1);

        // one-cycle glitch back to the same value: valid drops, no strobe
        tick(3);
        apply(pat_of(1), pat_of(8));
        tick(1);
        check("glitch_valid", {7'b0, value_valid}, 8'd0);
        accept_check(1, 7, 1'b0);

        // reset on the edge that would accept 25
        tick(2);
        apply(pat_of(2), pat_of(5));
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("rst_acc_strobe", {7'b0, value_strobe}, 8'd0);
        check("rst_acc_value", {2'b0, value}, 8'd0);
        check("rst_acc_valid", {7'b0, value_valid}, 8'd0);
        tick(1);
        check("rst_acc_strobe2", {7'b0, value_strobe}, 8'd0);

        // blank tens with units 7
        rst_n = 1'b1;
`ifdef SEG7_BLANK_LEADING_EN
        sb.push_back(6'd7);
        apply(7'h7F, pat_of(7));
        tick(5);
        check("blank_valid", {7'b0, value_valid}, 8'd1);
        check("blank_value", {2'b0, value}, 8'd7);
        check("blank_strobe", {7'b0, value_strobe}, 8'd1);
`else
        apply(7'h7F, pat_of(7));
        tick(4);
        check("blank_err_pre", {7'b0, pattern_err}, 8'd0);
        tick(1);
        check("blank_err", {7'b0, pattern_err}, 8'd1);
        check("blank_valid", {7'b0, value_valid}, 8'd0);
`endif
        tick(2);
        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
